// File: rtl/col_drain_sched.sv
// Round-robin drain scheduler: grants each ready PE column the shared output port
// for BURST_LEN beats and serves every column once per pass.
module col_drain_sched #(
  parameter int NUM_COL   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [NUM_COL-1:0]         req,
  input  logic                       beat_ready,
  output logic [NUM_COL-1:0]         grant,
  output logic [$clog2(NUM_COL)-1:0] tag_out,
  output logic                       flush,
  output logic                       beat_valid,
  output logic [NUM_COL-1:0]         served,
  output logic                       busy,
  output logic                       pass_done
);

  localparam int TW = $clog2(NUM_COL);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, ARB, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [NUM_COL-1:0] grant_q, grant_d;
  logic [TW-1:0]      tag_q, tag_d;
  logic [NUM_COL-1:0] served_q, served_d;
  logic [TW-1:0]      rr_q, rr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               first_q, first_d;

  logic [NUM_COL-1:0] pending;
  logic               sel_found;
  logic [TW-1:0]      sel_idx;
  logic [TW-1:0]      probe;

  // Search upward from rr_q; NUM_COL is a power of two so the index add wraps naturally.
  always_comb begin
    pending   = req & ~served_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    probe     = '0;
    for (int i = 0; i < NUM_COL; i++) begin
      probe = rr_q + TW'(i);
      if (!sel_found && pending[probe]) begin
        sel_found = 1'b1;
        sel_idx   = probe;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    tag_d    = tag_q;
    served_d = served_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    first_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          served_d = '0;
          state_d  = ARB;
        end
      end
      ARB: begin
        if (sel_found) begin
          tag_d   = sel_idx;
          grant_d = NUM_COL'(1) << sel_idx;
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = DRAIN;
        end else if (&served_q) begin
          state_d = DONE;
        end
      end
      DRAIN: begin
        if (beat_ready) begin
          if (cnt_q == LAST_BEAT) begin
            served_d[tag_q] = 1'b1;
            rr_d            = tag_q + TW'(1);
            grant_d         = '0;
            state_d         = ARB;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything but leaves pass bookkeeping untouched.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      grant_d  = '0;
      tag_d    = tag_q;
      served_d = served_q;
      rr_d     = rr_q;
      cnt_d    = cnt_q;
      first_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      tag_q    <= '0;
      served_q <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      tag_q    <= tag_d;
      served_q <= served_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
    end
  end

  assign grant      = grant_q;
  assign tag_out    = tag_q;
  assign served     = served_q;
  assign flush      = (state_q == DRAIN) && first_q;
  assign beat_valid = (state_q == DRAIN);
  assign busy       = (state_q != IDLE);
  assign pass_done  = (state_q == DONE);

endmodule

// File: tb/tb_col_drain_sched.sv
// Directed bench for col_drain_sched (NUM_COL=4, BURST_LEN=4): per-cycle vector
// tables for full passes and backpressure, hand sequences for late req, wrap, abort, reset.
module tb_col_drain_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       abort;
  logic [3:0] req;
  logic       beat_ready;
  logic [3:0] grant;
  logic [1:0] tag_out;
  logic       flush;
  logic       beat_valid;
  logic [3:0] served;
  logic       busy;
  logic       pass_done;

  always #5 clk = ~clk;

  col_drain_sched #(.NUM_COL(4), .BURST_LEN(4)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .abort      (abort),
    .req        (req),
    .beat_ready (beat_ready),
    .grant      (grant),
    .tag_out    (tag_out),
    .flush      (flush),
    .beat_valid (beat_valid),
    .served     (served),
    .busy       (busy),
    .pass_done  (pass_done)
  );

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] req;
    logic       br;
    logic [3:0] grant;
    logic [1:0] tag;
    logic       flush;
    logic       bv;
    logic [3:0] served;
    logic       busy;
    logic       pd;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic s, input logic a, input logic [3:0] r, input logic b,
                        input logic [3:0] g, input logic [1:0] t, input logic f,
                        input logic v, input logic [3:0] sv, input logic bz,
                        input logic pd);
    vec_t x;
    x.start = s;  x.abort = a;  x.req = r;    x.br = b;
    x.grant = g;  x.tag = t;    x.flush = f;  x.bv = v;
    x.served = sv; x.busy = bz; x.pd = pd;
    vecs.push_back(x);
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic [3:0] r, input logic b);
    start      = s;
    abort      = a;
    req        = r;
    beat_ready = b;
  endtask

  task automatic checkOutput(input string nm, input vec_t e);
    check({nm, ".grant"}, 32'(grant), 32'(e.grant));
    if (e.grant != 4'b0000) check({nm, ".tag"}, 32'(tag_out), 32'(e.tag));
    check({nm, ".flush"}, 32'(flush), 32'(e.flush));
    check({nm, ".beat_valid"}, 32'(beat_valid), 32'(e.bv));
    check({nm, ".served"}, 32'(served), 32'(e.served));
    check({nm, ".busy"}, 32'(busy), 32'(e.busy));
    check({nm, ".pass_done"}, 32'(pass_done), 32'(e.pd));
  endtask

  task automatic runVecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
      applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].req, vecs[i].br);
    end
  endtask

  task automatic checkAllZero(input string nm);
    check({nm, ".grant"}, 32'(grant), 32'h0);
    check({nm, ".tag"}, 32'(tag_out), 32'h0);
    check({nm, ".flush"}, 32'(flush), 32'h0);
    check({nm, ".beat_valid"}, 32'(beat_valid), 32'h0);
    check({nm, ".served"}, 32'(served), 32'h0);
    check({nm, ".busy"}, 32'(busy), 32'h0);
    check({nm, ".pass_done"}, 32'(pass_done), 32'h0);
  endtask

  initial begin
    logic [3:0] sv;
    logic [1:0] exp_order[4];
    logic [1:0] order[$];
    int         pd_count;
    int         pd_cyc;

    // All-ready pass: rows 0..23 (start row 0, DONE row 22).
    addVec(1, 0, 4'hF, 1, 4'h0, 2'd0, 0, 0, 4'h0, 0, 0);
    sv = 4'h0;
    for (int c = 0; c < 4; c++) begin
      addVec(0, 0, 4'hF, 1, 4'h0, 2'd0, 0, 0, sv, 1, 0);
      for (int b = 0; b < 4; b++)
        addVec(0, 0, 4'hF, 1, 4'(1 << c), 2'(c), (b == 0), 1, sv, 1, 0);
      sv = sv | 4'(1 << c);
    end
    addVec(0, 0, 4'hF, 1, 4'h0, 2'd0, 0, 0, 4'hF, 1, 0);
    addVec(0, 0, 4'hF, 1, 4'h0, 2'd0, 0, 0, 4'hF, 1, 1);
    addVec(0, 0, 4'hF, 1, 4'h0, 2'd0, 0, 0, 4'hF, 0, 0);
    // Backpressure on column 2 (rr_ptr=2 after the late-request pass): rows 24..34.
    addVec(1, 0, 4'hF, 1, 4'h0, 2'd0, 0, 0, 4'hF, 0, 0);
    addVec(0, 0, 4'hF, 1, 4'h0, 2'd0, 0, 0, 4'h0, 1, 0);
    for (int k = 0; k < 7; k++)
      addVec(0, 0, 4'hF, (k % 2 == 0), 4'b0100, 2'd2, (k == 0), 1, 4'h0, 1, 0);
    addVec(0, 1, 4'hF, 1, 4'h0, 2'd0, 0, 0, 4'b0100, 1, 0);
    addVec(0, 0, 4'hF, 1, 4'h0, 2'd0, 0, 0, 4'b0100, 0, 0);

    // Reset with start held high: everything stays zero.
    rstn = 1'b0;
    applyStimulus(1, 0, 4'hF, 1);
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    applyStimulus(0, 0, 4'h0, 1);
    rstn = 1'b1;

    runVecs(0, 23);

    // Late requests: column 3 arrives at cycle 30, column 1 at cycle 40.
    exp_order = '{2'd0, 2'd2, 2'd3, 2'd1};
    pd_count  = 0;
    pd_cyc    = -1;
    for (int cyc = 0; cyc < 48; cyc++) begin
      @(negedge clk);
      if (flush) order.push_back(tag_out);
      if (pass_done) begin
        pd_count++;
        pd_cyc = cyc;
      end
      if (cyc == 20) begin
        check("late.wait_grant", 32'(grant), 32'h0);
        check("late.wait_busy", 32'(busy), 32'h1);
      end
      applyStimulus((cyc == 0), 0,
                    4'b0101 | (cyc >= 30 ? 4'b1000 : 4'b0000) | (cyc >= 40 ? 4'b0010 : 4'b0000), 1);
    end
    check("late.grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) check($sformatf("late.order%0d", i), 32'(order[i]), 32'(exp_order[i]));
    check("late.pass_done_count", 32'(pd_count), 32'd1);
    check("late.pass_done_cycle", 32'(pd_cyc), 32'd46);
    check("late.served", 32'(served), 32'hF);

    runVecs(24, 34);

    // Wrap: rr_ptr=3 left by the abort above, req=1001 -> column 3 then column 0.
    pd_count = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (pass_done) pd_count++;
      if (cyc == 2) begin
        check("wrap.first_grant", 32'(grant), 32'b1000);
        check("wrap.first_tag", 32'(tag_out), 32'd3);
        check("wrap.first_flush", 32'(flush), 32'h1);
      end
      if (cyc == 7) begin
        check("wrap.second_grant", 32'(grant), 32'b0001);
        check("wrap.second_tag", 32'(tag_out), 32'd0);
      end
      if (cyc == 12) begin
        check("wrap.wait_grant", 32'(grant), 32'h0);
        check("wrap.wait_busy", 32'(busy), 32'h1);
        check("wrap.wait_served", 32'(served), 32'b1001);
      end
      if (cyc == 13) check("wrap.abort_idle", 32'(busy), 32'h0);
      applyStimulus((cyc == 0), (cyc == 12), 4'b1001, 1);
    end
    check("wrap.no_pass_done", 32'(pd_count), 32'd0);

    // Abort on beat 2 of column 1.
    pd_count = 0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      if (pass_done) pd_count++;
      if (cyc == 2) begin
        check("abort.grant", 32'(grant), 32'b0010);
        check("abort.flush", 32'(flush), 32'h1);
      end
      if (cyc == 3) check("abort.flush_once", 32'(flush), 32'h0);
      if (cyc == 4) check("abort.beat_valid", 32'(beat_valid), 32'h1);
      if (cyc == 5) begin
        check("abort.busy", 32'(busy), 32'h0);
        check("abort.grant_zero", 32'(grant), 32'h0);
        check("abort.served", 32'(served), 32'h0);
        check("abort.beat_valid_zero", 32'(beat_valid), 32'h0);
      end
      applyStimulus((cyc == 0), (cyc == 4), 4'b0010, 1);
    end
    check("abort.no_pass_done", 32'(pd_count), 32'd0);

    // Reset mid-DRAIN of column 1, asserted away from any clock edge.
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 2) check("rst.pre_grant", 32'(grant), 32'b0010);
      applyStimulus((cyc == 0), 0, 4'hF, 1);
    end
    #2 rstn = 1'b0;
    #1 checkAllZero("rst.async");
    @(negedge clk);
    checkAllZero("rst.held");
    rstn = 1'b1;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      if (cyc == 2) begin
        check("rst.rr_grant", 32'(grant), 32'b0001);
        check("rst.rr_tag", 32'(tag_out), 32'd0);
      end
      applyStimulus((cyc == 0), 0, 4'hF, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/col_drain_sched.md
COL_DRAIN_SCHED -- requirements
Module: col_drain_sched

Interface
- REQ-001 SHALL have parameter NUM_COL, default 4: number of PE columns sharing the output drain port; power of two, at least 2.
- REQ-002 SHALL have parameter BURST_LEN, default 4: beats drained per granted column; at least 1.
- REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
- REQ-004 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
- REQ-005 SHALL have port start, input, 1 bit: begins one drain pass.
- REQ-006 SHALL have port abort, input, 1 bit: synchronous pass cancel.
- REQ-007 SHALL have port req, input, NUM_COL bits: per-column "partial sums ready".
- REQ-008 SHALL have port beat_ready, input, 1 bit: downstream accepts a beat.
- REQ-009 SHALL have port grant, output, NUM_COL bits: one-hot column owner, or zero when no column owns the port.
- REQ-010 SHALL have port tag_out, output, $clog2(NUM_COL) bits: index of the granted column.
- REQ-011 SHALL have port flush, output, 1 bit: single-cycle flush pulse to the granted column's tag buffer.
- REQ-012 SHALL have port beat_valid, output, 1 bit: drain beat valid.
- REQ-013 SHALL have port served, output, NUM_COL bits: columns drained in the current pass.
- REQ-014 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
- REQ-015 SHALL have port pass_done, output, 1 bit: single-cycle pass-complete pulse.

Function
- REQ-016 SHALL implement registered FSM states IDLE, ARB, DRAIN, DONE.
- REQ-017 IDLE: start=1 SHALL clear served, go to ARB next cycle; start SHALL be ignored in all other states.
- REQ-018 ARB: pending = req & ~served; SHALL select the first set bit of pending searching upward from rr_ptr, wrapping NUM_COL-1 -> 0.
- REQ-019 ARB with pending nonzero: SHALL latch the selected index into tag_out, set grant one-hot, clear beat counter, go to DRAIN.
- REQ-020 ARB with pending zero and served all-ones SHALL go to DONE; with pending zero and served not all-ones, SHALL remain in ARB.
- REQ-021 DRAIN: flush SHALL be 1 only in the first DRAIN cycle of each grant.
- REQ-022 DRAIN: beat_valid SHALL be 1 every cycle; a beat completes on beat_valid&beat_ready; the beat counter SHALL increment per completed beat.
- REQ-023 On the completed beat with counter = BURST_LEN-1: SHALL set served[tag_out], set rr_ptr = (tag_out+1) mod NUM_COL, zero grant, go to ARB.
- REQ-024 During DRAIN, grant and tag_out SHALL hold even if req[tag_out] deasserts; beat_valid SHALL not drop without a handshake.
- REQ-025 DONE: pass_done SHALL be 1 for exactly one cycle, then IDLE; served SHALL hold its value until the next start.
- REQ-026 Outside DRAIN, grant SHALL be zero and flush and beat_valid SHALL be 0.
- REQ-027 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, zero grant, and suppress pass_done; served and rr_ptr SHALL hold.
- REQ-028 abort SHALL have priority over all other transitions; abort in IDLE SHALL have no effect.
- REQ-029 Grant latency SHALL be 1 cycle after an ARB cycle with pending nonzero; minimum pass length SHALL be NUM_COL*(BURST_LEN+1)+2 cycles.

Reset
- REQ-030 While rstn=0: state SHALL be IDLE and rr_ptr, served, grant, tag_out, beat counter SHALL be 0; flush, beat_valid, busy, pass_done SHALL be 0.
- REQ-031 Reset asserted mid-DRAIN SHALL take effect immediately; the interrupted column SHALL not be marked served.

Verification
- REQ-032 Scenario all-ready: NUM_COL=4, BURST_LEN=4, req=1111, beat_ready=1, start pulse -> grants 0,1,2,3 in order, each with 4 beats and 1 flush; pass_done 22 cycles after start; served=1111.
- REQ-033 Scenario backpressure: beat_ready toggles 1,0,1,0 -> beat_valid held high, counter advances only on handshakes, grant stable throughout.
- REQ-034 Scenario late request: req=0101 at start, req[3] set 30 cycles later, req[1] 10 cycles after that -> order 0,2,3,1; FSM waits in ARB between grants; pass_done after column 1 drains.
- REQ-035 Scenario wrap: rr_ptr=3 from a prior abort, req=1001 -> column 3 granted before column 0.
- REQ-036 Scenario abort/reset: abort on beat 2 of column 1 -> IDLE next cycle, served[1]=0, no pass_done; rstn low mid-DRAIN -> all outputs 0 asynchronously.
